// File: rtl/multibit_fifo_packer_if.sv
// Handshake bundle for multibit_fifo_packer: narrow input beat stream in, packed word stream out.
// master = surrounding logic (drives beats and m_ready), slave = the packer.
interface multibit_fifo_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    logic                      s_valid;
    logic [IN_WIDTH-1:0]       s_data;
    logic                      s_last;
    logic                      s_ready;
    logic                      m_valid;
    logic [IN_WIDTH*RATIO-1:0] m_data;
    logic [RATIO-1:0]          m_keep;
    logic                      m_last;
    logic                      m_ready;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last
    );
endinterface

// File: rtl/multibit_fifo_packer.sv
// Packs RATIO narrow beats into one word with keep/last; word visible 1 cycle after the closing beat.
// Backpressure: s_ready = !m_valid || m_ready; MULTIBIT_FIFO_PACKER_FLUSH_TIMEOUT_EN enables idle flush.
module multibit_fifo_packer #(
    parameter int IN_WIDTH       = 8,
    parameter int RATIO          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    multibit_fifo_packer_if.slave io_bus
);
    localparam int OUT_W = IN_WIDTH * RATIO;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (RATIO < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("multibit_fifo_packer: RATIO and TIMEOUT_CYCLES must be >= 1");
    end

    logic [OUT_W-1:0] r_data;
    logic [RATIO-1:0] r_keep;
    logic             r_valid;
    logic             r_last;
    logic [IDX_W-1:0] r_idx;

    logic w_s_ready;
    logic w_accept;
    logic w_close;
    logic w_flush;

    assign w_s_ready = !r_valid || io_bus.m_ready;
    assign w_accept  = io_bus.s_valid && w_s_ready;
    assign w_close   = (r_idx == LAST_IDX) || io_bus.s_last;

`ifdef MULTIBIT_FIFO_PACKER_FLUSH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // An accept in the timeout cycle wins: the beat is packed instead of flushing.
    assign w_flush = !w_accept && !r_valid && (r_idx != '0) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept || (r_idx == '0) || w_flush) begin
            r_cnt <= '0;
        end else if (!r_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            // idx is always 0 while a word is pending, so fire+accept restarts at lane 0.
            if (r_idx == '0) begin
                r_data <= OUT_W'(io_bus.s_data);
                r_keep <= RATIO'(1);
            end else begin
                for (int k = 1; k < RATIO; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_data[k*IN_WIDTH +: IN_WIDTH] <= io_bus.s_data;
                        r_keep[k]                      <= 1'b1;
                    end
                end
            end
            if (w_close) begin
                r_valid <= 1'b1;
                r_last  <= io_bus.s_last;
                r_idx   <= '0;
            end else begin
                r_valid <= 1'b0;
                r_idx   <= r_idx + IDX_W'(1);
            end
        end else if (w_flush) begin
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else if (r_valid && io_bus.m_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign io_bus.s_ready = w_s_ready;
    assign io_bus.m_valid = r_valid;
    assign io_bus.m_data  = r_data;
    assign io_bus.m_keep  = r_keep;
    assign io_bus.m_last  = r_last;
endmodule

// File: tb/tb_multibit_fifo_packer.sv
// Directed table-driven bench for multibit_fifo_packer (IN_WIDTH=8, RATIO=4, TIMEOUT_CYCLES=16).
module tb_multibit_fifo_packer;
    localparam int W = 8;
    localparam int R = 4;

    typedef struct {
        logic        sv;
        logic [7:0]  d;
        logic        sl;
        logic        mr;
        logic        exp_rdy;
        logic        exp_mv;
        logic [31:0] exp_dat;
        logic [3:0]  exp_keep;
        logic        exp_last;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multibit_fifo_packer_if #(.IN_WIDTH(W), .RATIO(R)) bus ();

    multibit_fifo_packer #(
        .IN_WIDTH(W),
        .RATIO(R),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic [7:0] d, input logic sl,
                                input logic mr, input logic rdy, input logic mv,
                                input logic [31:0] dat, input logic [3:0] keep,
                                input logic last);
        vec_t v;
        v.sv = sv; v.d = d; v.sl = sl; v.mr = mr;
        v.exp_rdy = rdy; v.exp_mv = mv; v.exp_dat = dat; v.exp_keep = keep; v.exp_last = last;
        return v;
    endfunction

    // Drive on the falling edge, check s_ready before the rising edge and outputs just after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.s_valid = v.sv;
        bus.s_data  = v.d;
        bus.s_last  = v.sl;
        bus.m_ready = v.mr;
        #1;
        check({tag, " s_ready"}, 32'(bus.s_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check({tag, " m_valid"}, 32'(bus.m_valid), 32'(v.exp_mv));
        if (v.exp_mv) begin
            check({tag, " m_data"}, bus.m_data, v.exp_dat);
            check({tag, " m_keep"}, 32'(bus.m_keep), 32'(v.exp_keep));
            check({tag, " m_last"}, 32'(bus.m_last), 32'(v.exp_last));
        end
    endtask

    initial begin
        logic [31:0] held;
        logic        seen_valid;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // 4 full beats
        vecs.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0));
        // short packet closed by s_last
        vecs.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        // continuous 12-beat stream
        vecs.push_back(mk(1, 8'hC0, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC1, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC2, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC3, 0, 1, 1, 1, 32'hC3C2C1C0, 4'hF, 0));
        vecs.push_back(mk(1, 8'hC4, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC5, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC6, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC7, 0, 1, 1, 1, 32'hC7C6C5C4, 4'hF, 0));
        vecs.push_back(mk(1, 8'hC8, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hC9, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hCA, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hCB, 0, 1, 1, 1, 32'hCBCAC9C8, 4'hF, 0));
        // stall 5 cycles with a beat waiting, then fire + accept together
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 8'hD0, 0, 0, 0, 1, 32'hCBCAC9C8, 4'hF, 0));
        vecs.push_back(mk(1, 8'hD0, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hD1, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hD2, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vecs.push_back(mk(1, 8'hD3, 0, 1, 1, 1, 32'hD3D2D1D0, 4'hF, 0));
        // single-beat packets; the second replaces the first on fire + accept
        vecs.push_back(mk(1, 8'h77, 1, 1, 1, 1, 32'h00000077, 4'h1, 1));
        vecs.push_back(mk(1, 8'h88, 1, 1, 1, 1, 32'h00000088, 4'h1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h00000088, 4'h1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));

        // asynchronous reset from time 1
        #1 reset = 1'b1;
        #1;
        check("reset m_valid", 32'(bus.m_valid), 32'h0);
        check("reset m_data", bus.m_data, 32'h0);
        check("reset m_keep", 32'(bus.m_keep), 32'h0);
        check("reset m_last", 32'(bus.m_last), 32'h0);
        check("reset s_ready", 32'(bus.s_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // a stalled word must hold every output bit
        apply(mk(1, 8'hE0, 1, 1, 1, 1, 32'h000000E0, 4'h1, 1), "stall_load");
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_data  = 8'hE1;
        held = bus.m_data;
        seen_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_data !== held || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0)
                seen_valid = 1'b0;
        end
        check("stall hold", 32'(seen_valid), 32'h1);
        apply(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0), "stall_drain");

        // asynchronous reset mid-cycle discards a partial word
        apply(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0), "pre_rst0");
        apply(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0), "pre_rst1");
        @(negedge clk);
        bus.s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst m_valid", 32'(bus.m_valid), 32'h0);
        check("midrst m_data", bus.m_data, 32'h0);
        check("midrst m_keep", 32'(bus.m_keep), 32'h0);
        check("midrst m_last", 32'(bus.m_last), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post_rst0");
        apply(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post_rst1");
        apply(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post_rst2");
        apply(mk(1, 8'h04, 0, 1, 1, 1, 32'h04030201, 4'hF, 0), "post_rst3");
        apply(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post_rst_idle");

        // one stale beat followed by idle
        apply(mk(1, 8'h5A, 0, 1, 1, 0, 32'h0, 4'h0, 0), "stale_beat");
        @(negedge clk);
        bus.s_valid = 1'b0;
`ifdef MULTIBIT_FIFO_PACKER_FLUSH_TIMEOUT_EN
        seen_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_valid === 1'b1) seen_valid = 1'b1;
        end
        check("timeout early", 32'(seen_valid), 32'h0);
        @(posedge clk);
        #1;
        check("timeout m_valid", 32'(bus.m_valid), 32'h1);
        check("timeout m_data", bus.m_data, 32'h0000005A);
        check("timeout m_keep", 32'(bus.m_keep), 32'h1);
        check("timeout m_last", 32'(bus.m_last), 32'h0);
`else
        seen_valid = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_valid === 1'b1) seen_valid = 1'b1;
        end
        check("no flush m_valid", 32'(seen_valid), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multibit_fifo_packer.md
Name: multibit_fifo_packer

Overview:
- Single-clock width up-converter sitting directly upstream of the 1-deep FIFO synchronizer, in the source (a) domain.
- Packs RATIO narrow beats of IN_WIDTH into one IN_WIDTH*RATIO word, so each CDC crossing carries a full word instead of one narrow beat.
- Provides a per-lane keep mask and a last flag so partial words at packet end are delivered without padding ambiguity.
- Output is a valid/ready stream that connects straight to the synchronizer's avalid/adata/aready.

Parameters:
- IN_WIDTH, 8, width of one input beat (lane).
- RATIO, 4, input beats per output word; must be >= 1. Output width = IN_WIDTH*RATIO.
- TIMEOUT_CYCLES, 16, idle cycles before a partial-word flush; used only with the optional feature; must be >= 1.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- s_valid  input  1  input beat valid.
- s_data  input  IN_WIDTH  input beat.
- s_last  input  1  marks the final beat of a packet.
- s_ready  output  1  packer can accept a beat.
- m_valid  output  1  packed word valid (drives the synchronizer's avalid).
- m_data  output  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH]; lane 0 is the first beat.
- m_keep  output  RATIO  bit k set = lane k holds a valid beat.
- m_last  output  1  word closes a packet.
- m_ready  input  1  downstream accepts the word (driven by the synchronizer's aready).

Behaviour:
- Reset (asynchronous, active-high): m_valid=0, m_data=0, m_keep=0, m_last=0, lane index idx=0, timeout counter=0. A partial word in progress when reset asserts is discarded.
- s_ready = !m_valid || m_ready. This is combinational and equals 1 out of reset. There is no combinational path from s_valid to m_valid.
- Accept: an input beat is accepted when s_valid && s_ready.
- Output fire: a word is transferred when m_valid && m_ready.
- On accept with idx==0: lane 0 <= s_data, all other lanes <= 0, m_keep <= 1.
- On accept with idx>0: lane idx <= s_data, m_keep[idx] <= 1. Other lanes are unchanged.
- Word close: when an accepted beat has idx==RATIO-1 or s_last=1:
  - m_valid <= 1 and m_last <= s_last on the next edge;
  - idx <= 0.
- Otherwise an accept does idx <= idx+1, and m_valid stays 0.
- Latency: the word is visible one cycle after the closing beat is accepted.
- Fire with no accept in the same cycle: m_valid <= 0. m_data and m_keep hold their values but are don't-care while m_valid=0.
- Fire and accept in the same cycle: the new beat starts a fresh word in lane 0, so back-to-back throughput is one beat per cycle.
  - If the new beat itself closes a word (RATIO==1 or s_last), m_valid stays 1 and the new word replaces the old one.
- Stall (m_valid && !m_ready): s_ready=0, and m_data, m_keep and m_last are held stable.
- Single-beat packet (s_last on the first beat) gives m_keep=...0001, m_last=1.
- RATIO==1: the block behaves as a registered pipeline stage; m_keep is always 1.
- m_data never changes while m_valid=1 and m_ready=0.

Optional Feature:
- Macro: MULTIBIT_FIFO_PACKER_FLUSH_TIMEOUT_EN.
- With the macro defined, a counter flushes a stale partial word:
  - The counter increments each cycle that idx!=0, m_valid=0 and no beat is accepted.
  - It clears on any accept and whenever idx==0.
  - When it reaches TIMEOUT_CYCLES, the next edge sets m_valid=1, m_last=0 and idx=0, and clears the counter. m_keep shows the filled lanes.
  - An accept in the same cycle as the timeout takes priority: the beat is packed and the counter clears.
- Without the macro, a partial word is held indefinitely until it fills or s_last arrives. No counter is synthesized.

Test Plan:
- Reset then 4 beats 0x11,0x22,0x33,0x44, s_last=0 on each, m_ready=1 -> one cycle after the 4th accept: m_data=0x44332211, m_keep=4'b1111, m_last=0. s_ready=1 throughout.
- Beats 0xAA,0xBB with s_last on 0xBB -> m_data=0x0000BBAA, m_keep=4'b0011, m_last=1. The next packet starts at lane 0.
- Continuous 12-beat stream with m_ready=1 -> 3 words on consecutive 4-cycle boundaries, no bubbles, s_ready never drops.
- Word pending with m_ready=0 for 5 cycles -> s_ready=0, m_data/m_keep/m_last stable, no beat lost. Asserting m_ready while s_valid=1 fires the word and accepts the beat as lane 0 in the same cycle.
- Assert reset asynchronously (mid-cycle) after 2 of 4 beats -> all outputs 0 immediately. The following 4 beats 0x01..0x04 produce 0x04030201, m_keep=4'b1111.
- With MULTIBIT_FIFO_PACKER_FLUSH_TIMEOUT_EN and TIMEOUT_CYCLES=16: one beat 0x5A then idle -> m_valid rises 16 idle cycles later with m_data=0x0000005A, m_keep=4'b0001, m_last=0. Without the macro, m_valid stays 0 for 100+ cycles.
